// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared condition-code and flag definitions for the ALU writeback path
package alu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_MI = 4'b0010,
    COND_PL = 4'b0011,
    COND_VS = 4'b0100,
    COND_VC = 4'b0101,
    COND_IV = 4'b0110,
    COND_NI = 4'b0111,
    COND_GE = 4'b1000,
    COND_LT = 4'b1001,
    COND_GT = 4'b1010,
    COND_LE = 4'b1011,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_I = 29;
  localparam int FLAG_V = 28;

  // Position of each flag inside the packed 4-bit NZIV nibble.
  localparam int NZIV_N = FLAG_N - FLAG_V;
  localparam int NZIV_Z = FLAG_Z - FLAG_V;
  localparam int NZIV_I = FLAG_I - FLAG_V;
  localparam int NZIV_V = 0;

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - execute-side input, register-file-side output and status bundle
interface alu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [31:0]       in_flags;
  logic [3:0]        in_cond;
  logic              in_set_flags;
  logic              in_wen;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_AW-1:0] out_rd;
  logic [31:0]       status;
  logic              busy;

  modport master (
    output in_valid, in_result, in_flags, in_cond, in_set_flags, in_wen, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, status, busy
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_cond, in_set_flags, in_wen, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, status, busy
  );
endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - evaluates a condition code against the NZIV flag nibble
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nziv,
  output logic       pass
);
  logic n, z, i, v;

  assign n = nziv[NZIV_N];
  assign z = nziv[NZIV_Z];
  assign i = nziv[NZIV_I];
  assign v = nziv[NZIV_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_IV: pass = i;
      COND_NI: pass = !i;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - conditional status commit and 2-entry register-write FIFO
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_writeback_if.slave bus
);
  logic [DATA_W-1:0] mem_data [2];
  logic [REG_AW-1:0] mem_rd   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [3:0]        nziv;
  logic              pass;
  logic              accept;
  logic              push;
  logic              pop;
  logic              set_flags;

  cond_check u_cond (
    .cond (bus.in_cond),
    .nziv (nziv),
    .pass (pass)
  );

  // Readiness depends only on registered occupancy so out_ready never reaches in_ready.
  assign bus.in_ready = (count != 2'd2);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && pass && bus.in_wen;
  assign pop          = (count != 2'd0) && bus.out_ready;
  assign set_flags    = accept && pass && bus.in_set_flags;

  assign bus.out_valid = (count != 2'd0);
  assign bus.busy      = (count != 2'd0);
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_rd    = mem_rd[rd_ptr];
  assign bus.status    = {nziv, 28'd0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mem_data[k] <= '0;
        mem_rd[k]   <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      nziv   <= 4'd0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= bus.in_result;
        mem_rd[wr_ptr]   <= bus.in_rd;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (set_flags) begin
        nziv <= bus.in_flags[FLAG_N:FLAG_V];
      end
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - vector table, directed corner sequences and randomized model check
module tb_alu_writeback;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_writeback_if #(.DATA_W(32), .REG_AW(4)) bus ();

  alu_writeback #(.DATA_W(32), .REG_AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  cond;
    logic        sf;
    logic [31:0] flags;
    logic        wen;
    logic [3:0]  rd;
    logic [31:0] res;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_rd;
    logic [31:0] e_status;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  rd;
  } ent_t;

  vec_t tbl [14];
  ent_t q [$];
  logic [3:0] ms;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic sf, input logic [31:0] fl,
                       input logic w, input logic [3:0] rd, input logic [31:0] res, input logic ordy);
    bus.in_valid     = v;
    bus.in_cond      = c;
    bus.in_set_flags = sf;
    bus.in_flags     = fl;
    bus.in_wen       = w;
    bus.in_rd        = rd;
    bus.in_result    = res;
    bus.out_ready    = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference rule for condition codes, stated over named flags.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] st);
    logic n, z, i, v;
    n = st[3]; z = st[2]; i = st[1]; v = st[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return n;
      4'd3:  return !n;
      4'd4:  return v;
      4'd5:  return !v;
      4'd6:  return i;
      4'd7:  return !i;
      4'd8:  return n == v;
      4'd9:  return n != v;
      4'd10: return !z && n == v;
      4'd11: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 4'd0, 0, 0, 0, 0, 0, 0);

    //            v cond  sf flags          wen rd    res           ordy irdy ov data          rd    status
    tbl[0]  = '{1, 4'd14, 0, 32'h0,         1, 4'd3,  32'h0000_0005, 1,  1,   1, 32'h5,        4'd3, 32'h0};
    tbl[1]  = '{1, 4'd14, 1, 32'h4000_0000, 0, 4'd0,  32'h0,         1,  1,   0, 32'h0,        4'd0, 32'h4000_0000};
    tbl[2]  = '{1, 4'd0,  0, 32'h0,         1, 4'd1,  32'h7,         0,  1,   1, 32'h7,        4'd1, 32'h4000_0000};
    tbl[3]  = '{1, 4'd1,  0, 32'h0,         1, 4'd2,  32'h9,         0,  1,   1, 32'h7,        4'd1, 32'h4000_0000};
    tbl[4]  = '{1, 4'd14, 1, 32'h8000_0000, 0, 4'd0,  32'h0,         1,  1,   0, 32'h0,        4'd0, 32'h8000_0000};
    tbl[5]  = '{1, 4'd9,  0, 32'h0,         1, 4'd4,  32'h11,        0,  1,   1, 32'h11,       4'd4, 32'h8000_0000};
    tbl[6]  = '{1, 4'd8,  0, 32'h0,         1, 4'd5,  32'h22,        0,  1,   1, 32'h11,       4'd4, 32'h8000_0000};
    tbl[7]  = '{1, 4'd14, 1, 32'h9000_0000, 1, 4'd6,  32'h33,        0,  0,   1, 32'h11,       4'd4, 32'h9000_0000};
    tbl[8]  = '{1, 4'd8,  0, 32'h0,         1, 4'd7,  32'h44,        1,  1,   1, 32'h33,       4'd6, 32'h9000_0000};
    tbl[9]  = '{1, 4'd8,  0, 32'h0,         1, 4'd7,  32'h44,        1,  1,   1, 32'h44,       4'd7, 32'h9000_0000};
    tbl[10] = '{1, 4'd14, 1, 32'h4000_0000, 0, 4'd0,  32'h0,         1,  1,   0, 32'h0,        4'd0, 32'h4000_0000};
    tbl[11] = '{1, 4'd11, 0, 32'h0,         1, 4'd8,  32'h55,        0,  1,   1, 32'h55,       4'd8, 32'h4000_0000};
    tbl[12] = '{1, 4'd10, 0, 32'h0,         1, 4'd9,  32'h66,        0,  1,   1, 32'h55,       4'd8, 32'h4000_0000};
    tbl[13] = '{1, 4'd12, 1, 32'h0,         1, 4'd10, 32'h77,        1,  1,   0, 32'h0,        4'd0, 32'h4000_0000};

    @(negedge clk);
    @(negedge clk);
    chk("rst_status", bus.status, 32'h0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_rd", {28'd0, bus.out_rd}, 32'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].v, tbl[r].cond, tbl[r].sf, tbl[r].flags, tbl[r].wen, tbl[r].rd, tbl[r].res, tbl[r].ordy);
      cyc();
      chk($sformatf("vec%0d_in_ready", r), {31'd0, bus.in_ready}, {31'd0, tbl[r].e_irdy});
      chk($sformatf("vec%0d_out_valid", r), {31'd0, bus.out_valid}, {31'd0, tbl[r].e_ov});
      chk($sformatf("vec%0d_status", r), bus.status, tbl[r].e_status);
      if (tbl[r].e_ov) begin
        chk($sformatf("vec%0d_out_data", r), bus.out_data, tbl[r].e_data);
        chk($sformatf("vec%0d_out_rd", r), {28'd0, bus.out_rd}, {28'd0, tbl[r].e_rd});
      end
    end

    // Backpressure: two fill the FIFO, the third is held until space opens.
    drive(1, 4'd14, 0, 0, 1, 4'd1, 32'hA1, 0); cyc();
    drive(1, 4'd14, 0, 0, 1, 4'd2, 32'hA2, 0); cyc();
    chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    drive(1, 4'd14, 0, 0, 1, 4'd3, 32'hA3, 0); cyc();
    chk("bp_stall_data", bus.out_data, 32'hA1);
    chk("bp_stall_rd", {28'd0, bus.out_rd}, 32'd1);
    chk("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1; cyc();
    chk("bp_drain1_rd", {28'd0, bus.out_rd}, 32'd2);
    chk("bp_drain1_data", bus.out_data, 32'hA2);
    cyc();
    chk("bp_drain2_rd", {28'd0, bus.out_rd}, 32'd3);
    chk("bp_drain2_data", bus.out_data, 32'hA3);
    bus.in_valid = 1'b0; cyc();
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_busy", {31'd0, bus.busy}, 32'd0);

    // Streaming: simultaneous push and pop keep occupancy at one.
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'd14, 0, 0, 1, i[3:0], 32'h100 + i, 1); cyc();
      chk($sformatf("stream%0d_rd", i), {28'd0, bus.out_rd}, i);
      chk($sformatf("stream%0d_data", i), bus.out_data, 32'h100 + i);
      chk($sformatf("stream%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0; cyc();
    chk("stream_end_empty", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of a full FIFO with all flags set.
    drive(1, 4'd14, 1, 32'hF000_0000, 1, 4'd1, 32'hB1, 0); cyc();
    drive(1, 4'd14, 0, 0, 1, 4'd2, 32'hB2, 0); cyc();
    chk("mid_full", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_status", bus.status, 32'hF000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_status", bus.status, 32'h0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    drive(1, 4'd14, 0, 0, 1, 4'd9, 32'h99, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_accept_rd", {28'd0, bus.out_rd}, 32'd9);
    chk("post_rst_accept_data", bus.out_data, 32'h99);
    drive(0, 4'd0, 0, 0, 0, 0, 0, 1); cyc();

    // Randomized traffic against a queue-based model.
    ms = 4'd0;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      logic v, sf, w, ordy, acc, pop, ok;
      logic [3:0] c, rd;
      logic [31:0] fl, res;
      chk("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      chk("rnd_out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      chk("rnd_busy", {31'd0, bus.busy}, {31'd0, q.size() > 0});
      chk("rnd_status", bus.status, {ms, 28'd0});
      if (q.size() > 0) begin
        chk("rnd_out_data", bus.out_data, q[0].d);
        chk("rnd_out_rd", {28'd0, bus.out_rd}, {28'd0, q[0].rd});
      end
      v    = ($urandom_range(0, 3) != 0);
      c    = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
      sf   = $urandom_range(0, 1) == 1;
      fl   = $urandom;
      w    = ($urandom_range(0, 3) != 0);
      rd   = 4'($urandom);
      res  = $urandom;
      ordy = $urandom_range(0, 1) == 1;
      drive(v, c, sf, fl, w, rd, res, ordy);
      acc = v && (q.size() < 2);
      ok  = acc && cond_ok(c, ms);
      pop = (q.size() > 0) && ordy;
      if (pop) void'(q.pop_front());
      if (ok && w) q.push_back('{d: res, rd: rd});
      if (ok && sf) ms = fl[31:28];
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
